// File: rtl/hd_cmd_pkg.sv
// hd_cmd_pkg: shared types and opcode decode for the HD63484-style command fetcher.
//   state_e      : fetcher FSM states (StIdle, StParam, StPresent)
//   Nib*/Sub*    : opcode nibble (op[15:12]) and control subtype (op[11:10]) constants
//   param_count  : op -> {known, count[3:0]}; count is the number of parameter words
package hd_cmd_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StParam,
        StPresent
    } state_e;

    localparam logic [3:0] NibCtl  = 4'h0;
    localparam logic [3:0] NibWptn = 4'h1;
    localparam logic [3:0] NibLine = 4'h4;
    localparam logic [3:0] NibRct  = 4'h5;
    localparam logic [3:0] NibCrcl = 4'hC;
    // 0x8..0xB all share op[15:14] = 2'b10 (AMOVE/RMOVE class)
    localparam logic [1:0] MoveClass = 2'b10;

    localparam logic [1:0] SubOrg = 2'b01;
    localparam logic [1:0] SubWpr = 2'b10;
    localparam logic [1:0] SubRpr = 2'b11;

    function automatic logic [4:0] param_count(input logic [15:0] op);
        logic [4:0] res;
        res = 5'b0;
        case (op[15:12])
            NibCtl: begin
                case (op[11:10])
                    SubOrg:  res = {1'b1, 4'd2};
                    SubWpr:  res = {1'b1, 4'd1};
                    SubRpr:  res = {1'b1, 4'd0};
                    default: res = 5'b0;
                endcase
            end
            NibWptn:         res = {1'b1, {1'b0, op[2:0]} + 4'd1};
            NibLine, NibRct: res = {1'b1, 4'd2};
            NibCrcl:         res = {1'b1, 4'd1};
            default: begin
                if (op[15:14] == MoveClass) res = {1'b1, 4'd2};
                else                        res = 5'b0;
            end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/hd_cmd_decode.sv
// hd_cmd_decode: combinational opcode decoder.
//   op    in  WIDTH  opcode word (decode uses op[15:0])
//   known out 1      opcode is recognised
//   count out 4      number of parameter words that follow
module hd_cmd_decode
    import hd_cmd_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] op,
    output logic             known,
    output logic [3:0]       count
);

    logic [4:0] dec;

    assign dec   = param_count(op[15:0]);
    assign known = dec[4];
    assign count = dec[3:0];

endmodule

// File: rtl/hd_cmd_fetch.sv
// hd_cmd_fetch: pops command words from a show-ahead FIFO, gathers the parameters of each
// opcode and presents one complete command over a valid/ready handshake.
//   clk, rst_n               clock, asynchronous active-low reset
//   fifo_empty, fifo_data    FIFO head (valid whenever !fifo_empty)
//   fifo_rd                  pop strobe (combinational)
//   cmd_valid, cmd_ready     command handshake
//   cmd_opcode/param_cnt/params  presented command, param[i] at [i*WIDTH +: WIDTH]
//   busy                     state is not idle
//   err_unknown              one-cycle pulse when an undecodable opcode is dropped
//   err_timeout              one-cycle pulse on starvation abort
// Build option: define HDCMD_TIMEOUT_EN to abort a command whose parameters starve for
// TIMEOUT_CYCLES cycles; otherwise err_timeout is tied 0 and the wait is unbounded.
module hd_cmd_fetch
    import hd_cmd_pkg::*;
#(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned MAX_PARAMS     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        fifo_empty,
    input  logic [WIDTH-1:0]            fifo_data,
    output logic                        fifo_rd,
    output logic                        cmd_valid,
    input  logic                        cmd_ready,
    output logic [WIDTH-1:0]            cmd_opcode,
    output logic [3:0]                  cmd_param_cnt,
    output logic [MAX_PARAMS*WIDTH-1:0] cmd_params,
    output logic                        busy,
    output logic                        err_unknown,
    output logic                        err_timeout
);

    state_e     state_q;
    logic [3:0] idx_q;
    logic       dec_known;
    logic [3:0] dec_count;

    hd_cmd_decode #(
        .WIDTH (WIDTH)
    ) u_decode (
        .op    (fifo_data),
        .known (dec_known),
        .count (dec_count)
    );

    // Never pops while presenting, so a backlog waits for acceptance.
    assign fifo_rd   = ((state_q == StIdle) || (state_q == StParam)) && !fifo_empty;
    assign busy      = (state_q != StIdle);
    assign cmd_valid = (state_q == StPresent);

`ifdef HDCMD_TIMEOUT_EN
    localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

    logic [TmoW-1:0] tmo_q;
    logic            err_timeout_q;

    assign err_timeout = err_timeout_q;
`else
    logic unused_tmo;

    assign unused_tmo  = ^TIMEOUT_CYCLES;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            idx_q         <= 4'd0;
            cmd_opcode    <= '0;
            cmd_param_cnt <= 4'd0;
            cmd_params    <= '0;
            err_unknown   <= 1'b0;
`ifdef HDCMD_TIMEOUT_EN
            tmo_q         <= '0;
            err_timeout_q <= 1'b0;
`endif
        end else begin
            err_unknown <= 1'b0;
`ifdef HDCMD_TIMEOUT_EN
            err_timeout_q <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        cmd_opcode    <= fifo_data;
                        cmd_params    <= '0;
                        cmd_param_cnt <= dec_count;
                        idx_q         <= 4'd0;
`ifdef HDCMD_TIMEOUT_EN
                        tmo_q         <= '0;
`endif
                        if (!dec_known)            err_unknown <= 1'b1;
                        else if (dec_count == 4'd0) state_q    <= StPresent;
                        else                        state_q    <= StParam;
                    end
                end
                StParam: begin
                    if (!fifo_empty) begin
                        for (int unsigned i = 0; i < MAX_PARAMS; i++) begin
                            if (idx_q == 4'(i)) cmd_params[i*WIDTH +: WIDTH] <= fifo_data;
                        end
                        idx_q <= idx_q + 4'd1;
`ifdef HDCMD_TIMEOUT_EN
                        tmo_q <= '0;
`endif
                        if (idx_q + 4'd1 == cmd_param_cnt) state_q <= StPresent;
                    end
`ifdef HDCMD_TIMEOUT_EN
                    else if (tmo_q == TmoLast) begin
                        // Starved: drop the partial command and leave outputs cleared.
                        state_q       <= StIdle;
                        err_timeout_q <= 1'b1;
                        tmo_q         <= '0;
                        idx_q         <= 4'd0;
                        cmd_opcode    <= '0;
                        cmd_param_cnt <= 4'd0;
                        cmd_params    <= '0;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                StPresent: begin
                    if (cmd_ready) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_hd_cmd_fetch.sv
`timescale 1ns/1ps
module tb_hd_cmd_fetch;

    localparam int W  = 16;
    localparam int MP = 8;
`ifdef HDCMD_TIMEOUT_EN
    localparam int TMO   = 16;
    localparam int STALL = 10;
`else
    localparam int TMO   = 1024;
    localparam int STALL = 50;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            fifo_empty = 1'b1;
    logic [W-1:0]    fifo_data = '0;
    logic            fifo_rd;
    logic            cmd_valid;
    logic            cmd_ready = 1'b0;
    logic [W-1:0]    cmd_opcode;
    logic [3:0]      cmd_param_cnt;
    logic [MP*W-1:0] cmd_params;
    logic            busy;
    logic            err_unknown;
    logic            err_timeout;

    always #5 clk = ~clk;

    hd_cmd_fetch #(
        .WIDTH          (W),
        .MAX_PARAMS     (MP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fifo_empty    (fifo_empty),
        .fifo_data     (fifo_data),
        .fifo_rd       (fifo_rd),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_opcode    (cmd_opcode),
        .cmd_param_cnt (cmd_param_cnt),
        .cmd_params    (cmd_params),
        .busy          (busy),
        .err_unknown   (err_unknown),
        .err_timeout   (err_timeout)
    );

    typedef struct {
        logic [15:0] data;
        bit          is_op;
    } word_t;

    typedef struct {
        logic [15:0]  op;
        logic [3:0]   cnt;
        logic [127:0] params;
        int           lat;
    } exp_t;

    word_t fq[$];
    exp_t  sb[$];

    bit hold = 1'b0;
    bit rd_seen = 1'b0;
    bit prev_valid = 1'b0;
    bit chk_next_pop = 1'b0;
    int cyc = 0;
    int last_op_cyc = -1;
    int accept_cyc = -100;
    int n_cmp = 0;
    int n_fail = 0;
    int n_unk = 0;
    int n_tmo = 0;

    logic [15:0]  snap_op;
    logic [3:0]   snap_cnt;
    logic [127:0] snap_params;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // FIFO model: head updated just after each edge; a word leaves when the DUT popped it.
    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        if (rd_seen && fq.size() > 0) void'(fq.pop_front());
        rd_seen    = 1'b0;
        fifo_empty = hold || (fq.size() == 0);
        fifo_data  = fifo_empty ? '0 : fq[0].data;
    end

    // Monitor / scoreboard, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        rd_seen = fifo_rd && rst_n;
        if (fifo_empty) check("rd_when_empty", fifo_rd, 1'b0);
        if (rd_seen && fq.size() > 0 && fq[0].is_op) begin
            if (chk_next_pop) begin
                check("pop_after_accept", cyc, accept_cyc + 1);
                chk_next_pop = 1'b0;
            end
            last_op_cyc = cyc;
        end
        if (err_unknown) n_unk++;
        if (err_timeout) n_tmo++;
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (prev_valid) begin
                check("valid_held", cmd_valid, 1'b1);
                check("hold_opcode", cmd_opcode, snap_op);
                check("hold_cnt", cmd_param_cnt, snap_cnt);
                check("hold_params", cmd_params, snap_params);
            end else if (cmd_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_cmd", cmd_opcode, 16'hFFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("opcode", cmd_opcode, e.op);
                    check("param_cnt", cmd_param_cnt, e.cnt);
                    check("params", cmd_params, e.params);
                    if (e.lat >= 0) check("latency", cyc - last_op_cyc, e.lat);
                end
                snap_op     = cmd_opcode;
                snap_cnt    = cmd_param_cnt;
                snap_params = cmd_params;
            end
            if (cmd_valid) check("rd_in_present", fifo_rd, 1'b0);
            if (cmd_valid && cmd_ready) accept_cyc = cyc;
            prev_valid = cmd_valid && !cmd_ready;
        end
    end

    task automatic push(input logic [15:0] d, input bit is_op);
        word_t w;
        w.data  = d;
        w.is_op = is_op;
        fq.push_back(w);
    endtask

    task automatic expect_cmd(input logic [15:0] op, input logic [3:0] cnt,
                              input logic [127:0] params, input int lat);
        exp_t e;
        e.op     = op;
        e.cnt    = cnt;
        e.params = params;
        e.lat    = lat;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while ((fq.size() != 0 || sb.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, n < budget, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_fifo_drained(input string name, input int budget);
        int n;
        n = 0;
        while (fq.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, n < budget, 1'b1);
    endtask

    initial begin
        logic [127:0] p;
        int base;

        // Reset state
        cmd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", cmd_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_opcode", cmd_opcode, 16'h0);
        check("rst_cnt", cmd_param_cnt, 4'd0);
        check("rst_params", cmd_params, 128'h0);
        check("rst_err_unknown", err_unknown, 1'b0);
        check("rst_err_timeout", err_timeout, 1'b0);
        step();
        rst_n = 1'b1;

        // WPR with one parameter
        step();
        push(16'h0800, 1'b1);
        push(16'h1234, 1'b0);
        expect_cmd(16'h0800, 4'd1, {112'h0, 16'h1234}, 2);
        wait_done("done_wpr", 50);

        // Unknown opcode dropped, then RPR with no parameters
        base = n_unk;
        step();
        push(16'h3000, 1'b1);
        push(16'h0C00, 1'b1);
        expect_cmd(16'h0C00, 4'd0, 128'h0, 1);
        wait_done("done_unknown", 50);
        check("err_unknown_pulses", n_unk - base, 1);

        // WPTN with eight parameters
        step();
        push(16'h1007, 1'b1);
        p = '0;
        for (int i = 0; i < 8; i++) begin
            push(16'hA000 + 16'(i), 1'b0);
            p[i*16 +: 16] = 16'hA000 + 16'(i);
        end
        expect_cmd(16'h1007, 4'd8, p, 9);
        wait_done("done_wptn", 60);
        check("wptn_param7", p[127:112], 16'hA007);

        // LINE with the second parameter arriving after a long empty stretch
        base = n_unk;
        step();
        push(16'h4000, 1'b1);
        push(16'h0005, 1'b0);
        expect_cmd(16'h4000, 4'd2, {96'h0, 16'h0010, 16'h0005}, -1);
        wait_fifo_drained("drain_line", 20);
        repeat (STALL) @(negedge clk);
        check("line_busy_stall", busy, 1'b1);
        check("line_valid_stall", cmd_valid, 1'b0);
        check("line_no_err", n_unk - base, 0);
        step();
        push(16'h0010, 1'b0);
        wait_done("done_line", 50);

        // Backlog held off while the downstream stalls
        step();
        cmd_ready = 1'b0;
        push(16'h0C00, 1'b1);
        push(16'h0800, 1'b1);
        push(16'h00AB, 1'b0);
        push(16'h0C00, 1'b1);
        expect_cmd(16'h0C00, 4'd0, 128'h0, 1);
        expect_cmd(16'h0800, 4'd1, {112'h0, 16'h00AB}, 2);
        expect_cmd(16'h0C00, 4'd0, 128'h0, 1);
        repeat (5) @(negedge clk);
        check("backlog_valid", cmd_valid, 1'b1);
        repeat (20) @(negedge clk);
        check("backlog_kept", fq.size(), 3);
        step();
        chk_next_pop = 1'b1;
        cmd_ready = 1'b1;
        wait_done("done_backlog", 50);
        check("pop_after_accept_seen", chk_next_pop, 1'b0);

        // Reset in the middle of ORG parameter gathering
        step();
        push(16'h0400, 1'b1);
        push(16'h0111, 1'b0);
        wait_fifo_drained("drain_org", 20);
        repeat (2) @(negedge clk);
        check("org_busy", busy, 1'b1);
        step();
        hold = 1'b1;
        push(16'h0C00, 1'b1);
        expect_cmd(16'h0C00, 4'd0, 128'h0, 1);
        step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_valid", cmd_valid, 1'b0);
        check("mid_rst_opcode", cmd_opcode, 16'h0);
        check("mid_rst_cnt", cmd_param_cnt, 4'd0);
        check("mid_rst_params", cmd_params, 128'h0);
        check("mid_rst_rd", fifo_rd, 1'b0);
        step();
        rst_n = 1'b1;
        hold = 1'b0;
        wait_done("done_after_rst", 50);

`ifdef HDCMD_TIMEOUT_EN
        // Starved ORG aborts after TMO empty cycles
        base = n_tmo;
        step();
        push(16'h0400, 1'b1);
        push(16'h0001, 1'b0);
        wait_fifo_drained("drain_tmo", 20);
        repeat (TMO + 8) @(negedge clk);
        check("err_timeout_pulses", n_tmo - base, 1);
        check("tmo_busy", busy, 1'b0);
        check("tmo_opcode", cmd_opcode, 16'h0);
        check("tmo_params", cmd_params, 128'h0);
`else
        check("no_timeout_pulses", n_tmo, 0);
`endif

        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/hd_cmd_fetch.md
Name: hd_cmd_fetch

Overview:
- Reader/consumer end of the command FIFO: pops 16-bit HD63484-style command words from a show-ahead FIFO, decodes the opcode to determine the parameter count, gathers the parameters and presents one complete command to the drawing engine over a valid/ready handshake.
- Sits between the host-side command FIFO and the drawing/register engine.

Parameters:
- WIDTH, 16, FIFO word width and opcode/parameter width.
- MAX_PARAMS, 8, parameter buffer depth; the largest count the decoder can produce.
- TIMEOUT_CYCLES, 1024, starvation limit; used only with HDCMD_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  WIDTH  FIFO head word (show-ahead, valid whenever !fifo_empty).
- fifo_rd  out  1  pop strobe; head is consumed in the cycle it is high.
- cmd_valid  out  1  a complete command is presented.
- cmd_ready  in  1  downstream accepts the command.
- cmd_opcode  out  WIDTH  captured opcode word.
- cmd_param_cnt  out  4  number of valid parameters (0..MAX_PARAMS).
- cmd_params  out  MAX_PARAMS*WIDTH  parameters; param[i] occupies bits [i*WIDTH +: WIDTH].
- busy  out  1  high whenever the state is not IDLE.
- err_unknown  out  1  one-cycle pulse when an undecodable opcode is dropped.
- err_timeout  out  1  one-cycle pulse on starvation abort; tied 0 when the timeout feature is compiled out.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0, including cmd_opcode, cmd_params and cmd_param_cnt. Any partial command is discarded. FIFO contents are untouched.
- fifo_rd = (state==IDLE || state==PARAM) && !fifo_empty. This signal is combinational and is never asserted in PRESENT, so the block never pops an empty FIFO.
- IDLE: on a pop, capture fifo_data into cmd_opcode, clear every cmd_params slot to 0 and decode the opcode.
  - Known opcode with count>0: go to PARAM.
  - Known opcode with count=0: go to PRESENT.
  - Unknown opcode: pulse err_unknown the next cycle, drop the word and stay in IDLE.
- Opcode decode (nibble = op[15:12]):
  - 0x0: subtype op[11:10]. 01=ORG, 2 params; 10=WPR, 1 param; 11=RPR, 0 params; 00=unknown.
  - 0x1: WPTN, op[2:0]+1 params (1..8).
  - 0x4, 0x5: LINE/RCT, 2 params.
  - 0x8 to 0xB: AMOVE/RMOVE class, 2 params.
  - 0xC: CRCL, 1 param.
  - All other nibbles: unknown.
- PARAM:
  - Each pop writes fifo_data into param[idx] and increments idx.
  - An empty FIFO stalls the state with no pop and no error.
  - After the pop of the last parameter, go to PRESENT.
- PRESENT:
  - cmd_valid=1, with cmd_opcode, cmd_params and cmd_param_cnt held stable.
  - On cmd_valid && cmd_ready, go to IDLE. The next opcode pop happens in the cycle after acceptance, so there is no back-to-back pop in the acceptance cycle.
- Latency: cmd_valid rises in the cycle after the last pop.
  - 0-param command: opcode pop at cycle 0, cmd_valid at cycle 1.
  - N params with no stalls: cmd_valid at cycle N+1.
- Parameter index and count are 4 bits wide. Indices only count up to the decoded count, so there is no wrap.
- Reset mid-PARAM or mid-PRESENT: the command is lost. The bench must not expect a replay.

Optional Feature:
- HDCMD_TIMEOUT_EN defined:
  - A counter clears on every pop and on entry to PARAM, and increments each PARAM cycle with fifo_empty=1.
  - When it reaches TIMEOUT_CYCLES, the block aborts to IDLE, pulses err_timeout for one cycle and leaves the outputs from the dropped command cleared.
- HDCMD_TIMEOUT_EN undefined: PARAM waits indefinitely, no counter logic exists, and err_timeout=0.

Decomposition:
- Package hd_cmd_pkg holds:
  - the state enum (IDLE, PARAM, PRESENT);
  - opcode nibble/subtype constants;
  - a function param_count(op) returning {known, count[3:0]}.
- Sub-module hd_cmd_decode is natural: a purely combinational opcode-to-{known,count} decoder instantiated once. Everything else stays in hd_cmd_fetch.

Test Plan:
- FIFO holds 0x0800, 0x1234; cmd_ready=1 -> two pops. Expected: cmd_valid for 1 cycle with opcode=0x0800, cnt=1, param0=0x1234, other params 0.
- FIFO holds 0x3000 then 0x0C00 -> err_unknown pulses once and 0x3000 is dropped. Expected: 0x0C00 (RPR) is presented with cnt=0, one cycle after its pop.
- WPTN 0x1007 followed by 8 params 0xA000..0xA007 -> cnt=8, param7=0xA007, cmd_valid at cycle 9 after the opcode pop.
- LINE 0x4000 and one param, then FIFO empty for 50 cycles, then second param 0x0010 -> no pops while empty, no error; command presented with param1=0x0010.
- cmd_ready held 0 for 20 cycles in PRESENT with a 3-word backlog -> fifo_rd stays 0 and outputs stay stable. Expected: after ready=1, the next opcode is popped in the following cycle.
- rst_n pulsed low mid-PARAM of ORG 0x0400 -> all outputs 0 immediately, state IDLE. The remaining FIFO word is then treated as an opcode. With HDCMD_TIMEOUT_EN and TIMEOUT_CYCLES=16: a starved ORG gives an err_timeout pulse after 16 empty cycles.
